regfile_write_queue: RTL and testbench

- Write-request buffer that sits directly upstream of the register file's 3-to-8 write-select decoder.
- Accepts register-write requests over a valid/ready handshake and queues them in a small FIFO.
- Issues at most one write per cycle as a 3-bit select, an enable and data, which feed the decoder and the register bank.
- Provides youngest-match forwarding so readers see queued, not-yet-committed writes.

---
 rtl/regfile_write_queue.sv | 117 +++++++++++
 tb/tb_regfile_write_queue.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_queue.sv
// Write-request queue in front of the register file's 3-to-8 write-select decoder.
// Buffers register writes, issues one per cycle in FIFO order, and forwards the youngest pending write.
module regfile_write_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 3
) (
    input  logic                  clock,
    input  logic                  ctrl_reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_addr,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  stall,
    output logic [2:0]            wr_ctrl,
    output logic                  wr_enable,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic [2:0]            query_addr,
    output logic                  query_hit,
    output logic [DATA_WIDTH-1:0] query_data,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  empty,
    output logic                  full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [2:0]            addr_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];

    logic accept;
    logic push;
    logic pop;

    // Status and handshake
    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_WIDTH'(DEPTH));
    assign count     = count_q;
    assign in_ready  = !full;
    assign accept    = in_valid && in_ready;
    // Writes to register 0 complete the handshake but are dropped here.
    assign push      = accept && (in_addr != 3'd0);
    assign pop       = !empty && !stall;
    assign wr_enable = pop;

    // Head entry drives the decoder; forced to zero when nothing is queued.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
        wr_ctrl = 3'd0;
        wr_data = '0;
        if (!empty) begin
            wr_ctrl = addr_q[head_q];
            wr_data = data_q[head_q];
        end
    end

    // Next-state: pop clears the head slot, push fills the tail slot.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end
        if (push) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PTR_W'(1);
        end
        count_d = count_q + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
    end

    // Walk oldest to youngest so the last match seen is the youngest.
    logic [PTR_W-1:0] scan_idx;
    always_comb begin
        query_hit  = 1'b0;
        query_data = '0;
        scan_idx   = '0;
        if (query_addr != 3'd0) begin
            for (int i = 0; i < DEPTH; i++) begin
                scan_idx = head_q + PTR_W'(i);
                if (valid_q[scan_idx] && (addr_q[scan_idx] == query_addr)) begin
                    query_hit  = 1'b1;
                    query_data = data_q[scan_idx];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // NOTE: entry storage is not reset; valid bits and the empty gate keep stale contents off every output.
    always_ff @(posedge clock) begin
        if (push) begin
            addr_q[tail_q] <= in_addr;
            data_q[tail_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed-vector bench for regfile_write_queue: reset, ordering, full/stall, wrap, register 0, forwarding.
module tb_regfile_write_queue;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clock = 1'b0;
    logic          ctrl_reset;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_addr;
    logic [DW-1:0] in_data;
    logic          stall;
    logic [2:0]    wr_ctrl;
    logic          wr_enable;
    logic [DW-1:0] wr_data;
    logic [2:0]    query_addr;
    logic          query_hit;
    logic [DW-1:0] query_data;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;

    int vectors    = 0;
    int miscompares = 0;

    regfile_write_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .stall      (stall),
        .wr_ctrl    (wr_ctrl),
        .wr_enable  (wr_enable),
        .wr_data    (wr_data),
        .query_addr (query_addr),
        .query_hit  (query_hit),
        .query_data (query_data),
        .count      (count),
        .empty      (empty),
        .full       (full)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Status bundle: {count, empty, full, in_ready, wr_enable}
    task automatic test_reset();
        ctrl_reset = 1'b1; in_valid = 1'b0; stall = 1'b0;
        in_addr = 3'd0; in_data = '0; query_addr = 3'd5;
        #12;
        vectors++;
        if ({count, empty, full, in_ready, wr_enable} !== {3'd0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            $display("FAIL reset_status got=%b exp=%b", {count, empty, full, in_ready, wr_enable}, 7'b000_1010);
            miscompares++;
        end
        vectors++;
        if ({wr_ctrl, wr_data, query_hit, query_data} !== '0) begin
            $display("FAIL reset_outputs got ctrl=%0d data=%h hit=%b qdata=%h exp all zero",
                     wr_ctrl, wr_data, query_hit, query_data);
            miscompares++;
        end
        ctrl_reset = 1'b0;
        tick();
        stall = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1; in_addr = 3'(i); in_data = 32'hBAD0_0000 + DW'(i);
            tick();
        end
        in_valid = 1'b0; query_addr = 3'd3;
        #1;
        vectors++;
        if ({count, query_hit, query_data} !== {3'd3, 1'b1, 32'hBAD0_0003}) begin
            $display("FAIL reset_prefill got count=%0d hit=%b qdata=%h exp count=3 hit=1 qdata=bad00003",
                     count, query_hit, query_data);
            miscompares++;
        end
        ctrl_reset = 1'b1; stall = 1'b0;
        #1;
        vectors++;
        if ({count, empty, wr_enable, query_hit} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin
            $display("FAIL reset_midcycle got count=%0d empty=%b wr_en=%b hit=%b exp 0 1 0 0",
                     count, empty, wr_enable, query_hit);
            miscompares++;
        end
        tick();
        ctrl_reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            vectors++;
            if ({count, wr_enable, wr_ctrl} !== {3'd0, 1'b0, 3'd0}) begin
                $display("FAIL reset_no_issue cycle=%0d got count=%0d wr_en=%b ctrl=%0d exp 0 0 0",
                         c, count, wr_enable, wr_ctrl);
                miscompares++;
            end
            tick();
        end
    endtask

    task automatic test_ordered_drain();
        stall = 1'b0;
        in_valid = 1'b1; in_addr = 3'd5; in_data = 32'hAAAA_0005;
        #1;
        vectors++;
        if ({in_ready, wr_enable} !== 2'b10) begin
            $display("FAIL drain_accept got ready=%b wr_en=%b exp 1 0", in_ready, wr_enable);
            miscompares++;
        end
        tick();
        in_addr = 3'd2; in_data = 32'h1234_5678;
        #1;
        vectors++;
        if ({wr_enable, wr_ctrl, wr_data} !== {1'b1, 3'd5, 32'hAAAA_0005}) begin
            $display("FAIL drain_first got en=%b ctrl=%0d data=%h exp 1 5 aaaa0005", wr_enable, wr_ctrl, wr_data);
            miscompares++;
        end
        tick();
        in_valid = 1'b0;
        #1;
        vectors++;
        if ({wr_enable, wr_ctrl, wr_data, count} !== {1'b1, 3'd2, 32'h1234_5678, 3'd1}) begin
            $display("FAIL drain_second got en=%b ctrl=%0d data=%h count=%0d exp 1 2 12345678 1",
                     wr_enable, wr_ctrl, wr_data, count);
            miscompares++;
        end
        tick();
        vectors++;
        if ({empty, wr_enable, wr_ctrl, wr_data} !== {1'b1, 1'b0, 3'd0, 32'h0}) begin
            $display("FAIL drain_empty got empty=%b en=%b ctrl=%0d data=%h exp 1 0 0 0",
                     empty, wr_enable, wr_ctrl, wr_data);
            miscompares++;
        end
    endtask

    task automatic test_full_stall();
        stall = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_addr = 3'(i); in_data = 32'hC0DE_0000 + DW'(i);
            tick();
        end
        in_addr = 3'd6; in_data = 32'hDEAD_BEEF;
        #1;
        vectors++;
        if ({count, empty, full, in_ready, wr_enable} !== {3'd4, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            $display("FAIL full_status got=%b exp=%b", {count, empty, full, in_ready, wr_enable}, 7'b100_0100);
            miscompares++;
        end
        tick();
        in_valid = 1'b0;
        #1;
        vectors++;
        if (count !== 3'd4) begin
            $display("FAIL full_reject got count=%0d exp 4", count);
            miscompares++;
        end
        stall = 1'b0;
        #1;
        vectors++;
        if ({in_ready, wr_enable, wr_ctrl, wr_data} !== {1'b0, 1'b1, 3'd1, 32'hC0DE_0001}) begin
            $display("FAIL full_pop got ready=%b en=%b ctrl=%0d data=%h exp 0 1 1 c0de0001",
                     in_ready, wr_enable, wr_ctrl, wr_data);
            miscompares++;
        end
        tick();
        for (int k = 2; k <= 4; k++) begin
            vectors++;
            if ({in_ready, wr_enable, wr_ctrl, wr_data, count} !==
                {1'b1, 1'b1, 3'(k), 32'hC0DE_0000 + DW'(k), 3'(5 - k)}) begin
                $display("FAIL full_drain k=%0d got ready=%b en=%b ctrl=%0d data=%h count=%0d exp 1 1 %0d %h %0d",
                         k, in_ready, wr_enable, wr_ctrl, wr_data, count, k, 32'hC0DE_0000 + DW'(k), 5 - k);
                miscompares++;
            end
            tick();
        end
        vectors++;
        if ({empty, count, wr_enable} !== {1'b1, 3'd0, 1'b0}) begin
            $display("FAIL full_empty got empty=%b count=%0d en=%b exp 1 0 0", empty, count, wr_enable);
            miscompares++;
        end
    endtask

    task automatic test_push_pop_wrap();
        logic [2:0]    exp_a [$];
        logic [DW-1:0] exp_d [$];
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_addr = 3'(6 + i); in_data = 32'h7700_0000 + DW'(i);
            exp_a.push_back(in_addr); exp_d.push_back(in_data);
            tick();
        end
        stall = 1'b0;
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1; in_addr = 3'((k % 7) + 1); in_data = 32'h5A00_0000 + DW'(k);
            #1;
            vectors++;
            if ({count, wr_enable, wr_ctrl, wr_data} !== {3'd2, 1'b1, exp_a[0], exp_d[0]}) begin
                $display("FAIL wrap k=%0d got count=%0d en=%b ctrl=%0d data=%h exp 2 1 %0d %h",
                         k, count, wr_enable, wr_ctrl, wr_data, exp_a[0], exp_d[0]);
                miscompares++;
            end
            exp_a.push_back(in_addr); exp_d.push_back(in_data);
            void'(exp_a.pop_front()); void'(exp_d.pop_front());
            tick();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if ({wr_enable, wr_ctrl, wr_data} !== {1'b1, exp_a[0], exp_d[0]}) begin
                $display("FAIL wrap_drain k=%0d got en=%b ctrl=%0d data=%h exp 1 %0d %h",
                         k, wr_enable, wr_ctrl, wr_data, exp_a[0], exp_d[0]);
                miscompares++;
            end
            void'(exp_a.pop_front()); void'(exp_d.pop_front());
            tick();
        end
        vectors++;
        if (empty !== 1'b1) begin
            $display("FAIL wrap_empty got empty=%b exp 1", empty);
            miscompares++;
        end
    endtask

    task automatic test_reg_zero();
        stall = 1'b0;
        in_valid = 1'b1; in_addr = 3'd0; in_data = 32'hFFFF_FFFF; query_addr = 3'd0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            $display("FAIL zero_handshake got ready=%b exp 1", in_ready);
            miscompares++;
        end
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            vectors++;
            if ({count, empty, wr_enable, query_hit, query_data} !== {3'd0, 1'b1, 1'b0, 1'b0, 32'h0}) begin
                $display("FAIL zero_ignored cycle=%0d got count=%0d empty=%b en=%b hit=%b qdata=%h exp 0 1 0 0 0",
                         c, count, empty, wr_enable, query_hit, query_data);
                miscompares++;
            end
            tick();
        end
    endtask

    task automatic test_forwarding();
        logic [2:0]    drain_q [4];
        logic [DW-1:0] drain_d [4];
        drain_q = '{3'd3, 3'd7, 3'd3, 3'd4};
        drain_d = '{32'h33, 32'h22, 32'h33, 32'h44};
        stall = 1'b1;
        in_valid = 1'b1; in_addr = 3'd3; in_data = 32'h11; tick();
        in_addr = 3'd7; in_data = 32'h22; tick();
        in_addr = 3'd3; in_data = 32'h33; tick();
        in_addr = 3'd4; in_data = 32'h44;
        query_addr = 3'd3; #1;
        vectors++;
        if ({query_hit, query_data} !== {1'b1, 32'h33}) begin
            $display("FAIL fwd_youngest got hit=%b data=%h exp 1 00000033", query_hit, query_data);
            miscompares++;
        end
        query_addr = 3'd4; #1;
        vectors++;
        if ({query_hit, query_data} !== {1'b0, 32'h0}) begin
            $display("FAIL fwd_same_cycle got hit=%b data=%h exp 0 0", query_hit, query_data);
            miscompares++;
        end
        query_addr = 3'd0; #1;
        vectors++;
        if ({query_hit, query_data} !== {1'b0, 32'h0}) begin
            $display("FAIL fwd_reg0 got hit=%b data=%h exp 0 0", query_hit, query_data);
            miscompares++;
        end
        tick();
        in_valid = 1'b0;
        query_addr = 3'd4; #1;
        vectors++;
        if ({query_hit, query_data} !== {1'b1, 32'h44}) begin
            $display("FAIL fwd_next_cycle got hit=%b data=%h exp 1 00000044", query_hit, query_data);
            miscompares++;
        end
        stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            query_addr = drain_q[k]; #1;
            vectors++;
            if ({wr_enable, wr_ctrl, query_hit, query_data} !== {1'b1, drain_q[k], 1'b1, drain_d[k]}) begin
                $display("FAIL fwd_issuing k=%0d got en=%b ctrl=%0d hit=%b data=%h exp 1 %0d 1 %h",
                         k, wr_enable, wr_ctrl, query_hit, query_data, drain_q[k], drain_d[k]);
                miscompares++;
            end
            tick();
        end
        query_addr = 3'd4; #1;
        vectors++;
        if ({empty, query_hit, query_data} !== {1'b1, 1'b0, 32'h0}) begin
            $display("FAIL fwd_after_drain got empty=%b hit=%b data=%h exp 1 0 0", empty, query_hit, query_data);
            miscompares++;
        end
    endtask

    initial begin
        test_reset();
        test_ordered_drain();
        test_full_stall();
        test_push_pop_wrap();
        test_reg_zero();
        test_forwarding();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
